fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_hold_buf.sv | 47 ++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: stall bus width, boot address,
// IF2->ID bus layout and a word-alignment helper.
package fetch_unit_pkg;

  localparam int          STALL_W_DEF     = 6;
  localparam int          STALL_FETCH_BIT = 1;
  localparam logic [31:0] RESET_PC_DEF    = 32'h8000_0000;

  // if22id_bus = {inst[31:0], pc_valid, pc[31:0]}
  localparam int IF22ID_W_DEF = 65;
  localparam int BUS_PC_LSB   = 0;
  localparam int BUS_VLD_BIT  = 32;
  localparam int BUS_INST_LSB = 33;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// IF2 instruction hold buffer: captures the SRAM word on the first frozen
// cycle and replays it for the rest of the stall, since the SRAM is not
// read while fetch is frozen and its output cannot be trusted.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        freeze_i,
  input  logic        valid_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] inst_o
);

  logic        hold_q, hold_d;
  logic [31:0] hold_inst_q, hold_inst_d;

  // Capture once per stall; flush or release drops the held word.
  always_comb begin
    hold_d      = hold_q;
    hold_inst_d = hold_inst_q;
    if (flush_i) begin
      hold_d = 1'b0;
    end else if (freeze_i) begin
      if (!hold_q) begin
        hold_d      = 1'b1;
        hold_inst_d = rdata_i;
      end
    end else begin
      hold_d = 1'b0;
    end
  end

  // Hold state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q      <= 1'b0;
      hold_inst_q <= '0;
    end else begin
      hold_q      <= hold_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // A bubble never carries an instruction word.
  assign inst_o = !valid_i ? 32'h0 : (hold_q ? hold_inst_q : rdata_i);

endmodule

// File: rtl/fetch_unit.sv
// Two-stage fetch: IF1 picks the next PC and reads the 1-cycle SRAM,
// IF2 pairs the returned word with its PC for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          IF22ID_WD = IF22ID_W_DEF,
  parameter int          STALL_WD  = STALL_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  input  logic [STALL_WD-1:0]  stall,
  input  logic [32:0]          br_bus,
  output logic                 inst_sram_en,
  output logic [31:0]          inst_sram_addr,
  input  logic [31:0]          inst_sram_rdata,
  output logic [IF22ID_WD-1:0] if22id_bus
);

  logic        br_e;
  logic [31:0] br_addr;
  logic        freeze;
  logic        unused_stall;

  logic        boot_q, boot_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] next_pc_raw, next_pc;
  logic [31:0] inst;

  assign {br_e, br_addr} = br_bus;
  assign freeze          = stall[STALL_FETCH_BIT];
  assign unused_stall    = ^stall;

  // Next fetch address; flush beats freeze, freeze beats branch, branch beats boot.
  always_comb begin
    next_pc_raw = pc_q + 32'd4;
    if (flush)       next_pc_raw = flush_pc;
    else if (freeze) next_pc_raw = pc_q;
    else if (br_e)   next_pc_raw = br_addr;
    else if (boot_q) next_pc_raw = RESET_PC;
  end

  assign next_pc        = word_align(next_pc_raw);
  assign inst_sram_addr = next_pc;
  assign inst_sram_en   = rst_n & (flush | ~freeze);

  // IF2 state advances whenever a read was issued; a freeze holds everything.
  always_comb begin
    boot_d  = boot_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush || !freeze) begin
      boot_d  = 1'b0;
      pc_d    = next_pc;
      valid_d = 1'b1;
    end
  end

  // IF2 PC / valid / boot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      boot_q  <= 1'b1;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      boot_q  <= boot_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .freeze_i (freeze),
    .valid_i  (valid_q),
    .rdata_i  (inst_sram_rdata),
    .inst_o   (inst)
  );

  // Decode sees an all-zero bus while reset is held.
  always_comb begin
    if22id_bus = '0;
    if (rst_n) begin
      if22id_bus[BUS_INST_LSB +: 32] = inst;
      if22id_bus[BUS_VLD_BIT]        = valid_q;
      if22id_bus[BUS_PC_LSB +: 32]   = pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table for the documented scenarios,
// then randomized traffic against a behavioural fetch model. The SRAM model
// returns addr>>2 on a read and garbage when not enabled, so a valid bus entry
// must always carry (pc>>2) as its instruction.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    flush;
  logic [31:0]             flush_pc;
  logic [STALL_W_DEF-1:0]  stall;
  logic [32:0]             br_bus;
  logic                    en;
  logic [31:0]             addr;
  logic [31:0]             rdata = 32'h0;
  logic [IF22ID_W_DEF-1:0] bus;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .stall           (stall),
    .br_bus          (br_bus),
    .inst_sram_en    (en),
    .inst_sram_addr  (addr),
    .inst_sram_rdata (rdata),
    .if22id_bus      (bus)
  );

  // Synchronous SRAM: 1-cycle read; output scrambled when not read.
  always @(posedge clk) rdata <= en ? (addr >> 2) : $urandom;

  typedef struct {
    logic        r;
    logic        fl;
    logic [31:0] fpc;
    logic        st;
    logic        br;
    logic [31:0] ba;
    logic        en;
    logic [31:0] addr;
    logic [31:0] pc;
    logic        v;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, fl, input logic [31:0] fpc, input logic st, br,
                     input logic [31:0] ba, input logic e, input logic [31:0] a, pc,
                     input logic v);
    vec_t t;
    t.r = r; t.fl = fl; t.fpc = fpc; t.st = st; t.br = br; t.ba = ba;
    t.en = e; t.addr = a; t.pc = pc; t.v = v;
    tbl.push_back(t);
  endtask

  function automatic logic [64:0] exp_bus(input logic r, v, input logic [31:0] pc);
    if (!r) return 65'h0;
    return {(v ? (pc >> 2) : 32'h0), v, pc};
  endfunction

  task automatic chk(input string nm, input int idx, input logic [64:0] act, exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Applied at negedge; outputs sampled 1ns later, well before the next posedge.
  task automatic drive(input logic r, fl, input logic [31:0] fpc, input logic st, br,
                       input logic [31:0] ba);
    logic [STALL_W_DEF-1:0] s;
    @(negedge clk);
    s = STALL_W_DEF'($urandom);
    s[STALL_FETCH_BIT] = st;
    rst_n = r; flush = fl; flush_pc = fpc; stall = s; br_bus = {br, ba};
    #1;
  endtask

  // Behavioural model state: what IF2 currently presents.
  logic        m_boot, m_v;
  logic [31:0] m_pc;

  initial begin
    logic        r, fl, st, br, e;
    logic [31:0] fpc, ba, a;

    rst_n = 1'b0; flush = 1'b0; flush_pc = '0; stall = '0; br_bus = '0;

    // Directed sequence, starting from a reset state.
    add(0,0,0,0,0,0,             0, RPC,            32'h0,          0);
    add(1,0,0,0,0,0,             1, RPC,            32'h0,          0);
    add(1,0,0,0,0,0,             1, 32'h8000_0004,  RPC,            1);
    add(1,0,0,0,0,0,             1, 32'h8000_0008,  32'h8000_0004,  1);
    add(1,0,0,1,0,0,             0, 32'h8000_0008,  32'h8000_0008,  1);
    add(1,0,0,1,0,0,             0, 32'h8000_0008,  32'h8000_0008,  1);
    add(1,0,0,1,0,0,             0, 32'h8000_0008,  32'h8000_0008,  1);
    add(1,0,0,0,0,0,             1, 32'h8000_000C,  32'h8000_0008,  1);
    add(1,0,0,0,0,0,             1, 32'h8000_0010,  32'h8000_000C,  1);
    add(1,0,0,0,1,32'h8000_0102, 1, 32'h8000_0100,  32'h8000_0010,  1);
    add(1,0,0,0,0,0,             1, 32'h8000_0104,  32'h8000_0100,  1);
    add(1,1,32'h200,1,1,32'h8000_0400, 1, 32'h200,  32'h8000_0104,  1);
    add(1,0,0,0,0,0,             1, 32'h204,        32'h200,        1);
    add(1,0,0,1,1,32'h1234_5678, 0, 32'h204,        32'h204,        1);
    add(1,0,0,0,0,0,             1, 32'h208,        32'h204,        1);
    add(1,0,0,1,0,0,             0, 32'h208,        32'h208,        1);
    add(0,0,0,1,0,0,             0, 32'h208,        32'h0,          0);
    add(1,0,0,0,0,0,             1, RPC,            32'h0,          0);
    add(1,0,0,0,0,0,             1, 32'h8000_0004,  RPC,            1);
    add(1,1,32'hFFFF_FFFE,0,0,0, 1, 32'hFFFF_FFFC,  32'h8000_0004,  1);
    add(1,0,0,0,0,0,             1, 32'h0,          32'hFFFF_FFFC,  1);
    add(1,0,0,0,0,0,             1, 32'h4,          32'h0,          1);

    drive(0,0,0,0,0,0);
    drive(0,0,0,0,0,0);
    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].fl, tbl[i].fpc, tbl[i].st, tbl[i].br, tbl[i].ba);
      chk("tbl_en",   i, 65'(en),   65'(tbl[i].en));
      chk("tbl_addr", i, 65'(addr), 65'(tbl[i].addr));
      chk("tbl_bus",  i, 65'(bus),  exp_bus(tbl[i].r, tbl[i].v, tbl[i].pc));
    end

    // Randomized traffic against the model.
    m_boot = 1'b1; m_v = 1'b0; m_pc = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      r   = (i < 2) ? 1'b0 : ($urandom_range(99) != 0);
      fl  = ($urandom_range(19) == 0);
      st  = ($urandom_range(3) == 0);
      br  = ($urandom_range(7) == 0);
      fpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      ba  = $urandom;
      drive(r, fl, fpc, st, br, ba);

      e = r & (fl | ~st);
      if (fl)          a = fpc;
      else if (st)     a = m_pc;
      else if (br)     a = ba;
      else if (m_boot) a = RPC;
      else             a = m_pc + 32'd4;
      a[1:0] = 2'b00;

      chk("rnd_en", i, 65'(en), 65'(e));
      if (i > 0) chk("rnd_addr", i, 65'(addr), 65'(a));
      chk("rnd_bus", i, 65'(bus), exp_bus(r, m_v, m_pc));

      // Model update for the coming edge.
      if (!r) begin
        m_boot = 1'b1; m_v = 1'b0; m_pc = 32'h0;
      end else if (fl || !st) begin
        m_boot = 1'b0; m_v = 1'b1; m_pc = a;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
